// File: rtl/fp_pkg.sv
// Shared IEEE-754 descriptors for the FP datapath: format geometry, operand classes,
// exception flag layout and canonical special encodings.
package fp_pkg;

  typedef struct packed {
    int unsigned exp_w;
    int unsigned man_w;
    int unsigned bias;
  } fp_fmt_t;

  localparam fp_fmt_t FmtBinary32 = '{exp_w: 8, man_w: 23, bias: 127};
  localparam fp_fmt_t FmtBinary64 = '{exp_w: 11, man_w: 52, bias: 1023};

  function automatic fp_fmt_t fmt_of(int unsigned n);
    return (n == 64) ? FmtBinary64 : FmtBinary32;
  endfunction

  typedef enum logic [2:0] {
    ClsZero,
    ClsNorm,
    ClsInf,
    ClsQnan,
    ClsSnan
  } fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  localparam logic [31:0] QNan32 = 32'h7FC0_0000;
  localparam logic [31:0] Inf32  = 32'h7F80_0000;
  localparam logic [63:0] QNan64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] Inf64  = 64'h7FF0_0000_0000_0000;

  function automatic logic [63:0] qnan_of(int unsigned n);
    return (n == 64) ? QNan64 : {32'h0, QNan32};
  endfunction

  function automatic logic [63:0] inf_of(int unsigned n);
    return (n == 64) ? Inf64 : {32'h0, Inf32};
  endfunction

endpackage

// File: rtl/fmul_pipe_if.sv
// Operand/result handshake bundle for fmul_pipe: request side (operands + tag) and
// response side (product + tag + flags), each with its own valid/ready pair.
interface fmul_pipe_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic [N-1:0]     b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, out_flags
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, out_flags
  );

endinterface

// File: rtl/fp_round.sv
// Normalise a [1,4) significand product, round to nearest-even, detect overflow/underflow
// and pack the IEEE result. Purely combinational.
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned ExpW = 8,
  parameter int unsigned ManW = 23
) (
  input  logic              sign_i,
  input  logic [ExpW+1:0]   exp_i,
  input  logic [2*ManW+1:0] prod_i,
  output logic [N-1:0]      res_o,
  output fp_flags_t         flags_o
);

  localparam logic [ExpW+1:0] ExpMax = {2'b00, {ExpW{1'b1}}};

  logic [2*ManW:0] norm;
  logic [ExpW+1:0] exp_n;
  logic [ExpW+1:0] exp_f;
  logic [ManW:0]   man_r;
  logic            g, r, s, up, ovf, unf;

  always_comb begin
    // Drop the leading one; norm holds fraction bits followed by guard/round/sticky.
    norm  = prod_i[2*ManW+1] ? prod_i[2*ManW:0] : {prod_i[2*ManW-1:0], 1'b0};
    exp_n = exp_i + {{(ExpW+1){1'b0}}, prod_i[2*ManW+1]};

    g  = norm[ManW];
    r  = norm[ManW-1];
    s  = |norm[ManW-2:0];
    up = g & (r | s | norm[ManW+1]);

    man_r = {1'b0, norm[2*ManW:ManW+1]} + {{ManW{1'b0}}, up};
    exp_f = exp_n + {{(ExpW+1){1'b0}}, man_r[ManW]};

    ovf = !exp_f[ExpW+1] && (exp_f >= ExpMax);
    unf = exp_f[ExpW+1] || (exp_f == '0);

    res_o   = '0;
    flags_o = '0;
    if (ovf) begin
      res_o             = {sign_i, ExpMax[ExpW-1:0], {ManW{1'b0}}};
      flags_o.overflow  = 1'b1;
      flags_o.inexact   = 1'b1;
    end else if (unf) begin
      res_o             = {sign_i, {(N-1){1'b0}}};
      flags_o.underflow = 1'b1;
      flags_o.inexact   = 1'b1;
    end else begin
      // On mantissa carry-out man_r[ManW-1:0] is already zero.
      res_o           = {sign_i, exp_f[ExpW-1:0], man_r[ManW-1:0]};
      flags_o.inexact = g | r | s;
    end
  end

endmodule

// File: rtl/nmul.sv
// Unsigned W x W significand multiplier producing the full 2W-bit product.
module nmul #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage IEEE-754 multiplier (classify/exponent, significand multiply, round/pack)
// with a single global advance so the whole pipe stalls together under backpressure.
module fmul_pipe
  import fp_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic        clk,
  input logic        rst,
  fmul_pipe_if.slave bus
);

  localparam fp_fmt_t         Fmt   = fmt_of(N);
  localparam int unsigned     ExpW  = Fmt.exp_w;
  localparam int unsigned     ManW  = Fmt.man_w;
  localparam int unsigned     SigW  = ManW + 1;
  localparam int unsigned     ExpSW = ExpW + 2;
  localparam logic [ExpW+1:0] BiasE = ExpSW'(Fmt.bias);
  localparam logic [N-1:0]    QNan  = N'(qnan_of(N));
  localparam logic [N-1:0]    Inf   = N'(inf_of(N));

  if (!(N == 32 || N == 64)) begin : g_bad_width
    $error("fmul_pipe: N must be 32 or 64");
  end

  function automatic fp_class_e classify(logic [N-1:0] x);
    logic [ExpW-1:0] e;
    logic [ManW-1:0] m;
    e = x[N-2 -: ExpW];
    m = x[ManW-1:0];
    if (e == '0) return ClsZero;
    if (e != '1) return ClsNorm;
    if (m == '0) return ClsInf;
    return m[ManW-1] ? ClsQnan : ClsSnan;
  endfunction

  logic advance;

  // Stage 1 combinational: classification and exponent sum.
  fp_class_e       cls_a, cls_b;
  logic            sign_d, spec_d;
  logic [N-1:0]    sres_d;
  fp_flags_t       sflg_d;
  logic [ExpW+1:0] exp_d;

  always_comb begin
    cls_a  = classify(bus.a);
    cls_b  = classify(bus.b);
    sign_d = bus.a[N-1] ^ bus.b[N-1];
    exp_d  = {2'b00, bus.a[N-2 -: ExpW]} + {2'b00, bus.b[N-2 -: ExpW]} - BiasE;
    spec_d = 1'b1;
    sres_d = '0;
    sflg_d = '0;
    if (cls_a inside {ClsQnan, ClsSnan} || cls_b inside {ClsQnan, ClsSnan}) begin
      sres_d         = QNan;
      sflg_d.invalid = (cls_a == ClsSnan) || (cls_b == ClsSnan);
    end else if ((cls_a == ClsInf && cls_b == ClsZero) ||
                 (cls_a == ClsZero && cls_b == ClsInf)) begin
      sres_d         = QNan;
      sflg_d.invalid = 1'b1;
    end else if (cls_a == ClsInf || cls_b == ClsInf) begin
      sres_d = {sign_d, Inf[N-2:0]};
    end else if (cls_a == ClsZero || cls_b == ClsZero) begin
      sres_d = {sign_d, {(N-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic             v1_q, v2_q, v3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic             sign1_q, sign2_q;
  logic             spec1_q, spec2_q;
  logic [N-1:0]     sres1_q, sres2_q;
  fp_flags_t        sflg1_q, sflg2_q;
  logic [ExpW+1:0]  exp1_q, exp2_q;
  logic [SigW-1:0]  siga1_q, sigb1_q;
  logic [2*SigW-1:0] prod_d, prod2_q;
  logic [N-1:0]     out_q;
  fp_flags_t        flags3_q;

  nmul #(
    .W (SigW)
  ) u_nmul (
    .a_i (siga1_q),
    .b_i (sigb1_q),
    .p_o (prod_d)
  );

  logic [N-1:0] rnd_res;
  fp_flags_t    rnd_flg;
  logic [N-1:0] out_d;
  fp_flags_t    flags_d;

  fp_round #(
    .N    (N),
    .ExpW (ExpW),
    .ManW (ManW)
  ) u_round (
    .sign_i  (sign2_q),
    .exp_i   (exp2_q),
    .prod_i  (prod2_q),
    .res_o   (rnd_res),
    .flags_o (rnd_flg)
  );

  always_comb begin
    out_d   = spec2_q ? sres2_q : rnd_res;
    flags_d = spec2_q ? sflg2_q : rnd_flg;
  end

  assign advance = !v3_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      out_q    <= '0;
      tag3_q   <= '0;
      flags3_q <= '0;
    end else if (advance) begin
      v1_q     <= bus.in_valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      out_q    <= out_d;
      tag3_q   <= tag2_q;
      flags3_q <= flags_d;
    end
  end

  // Payload registers need no reset: they are only observed behind their valid bits.
  always_ff @(posedge clk) begin
    if (advance) begin
      tag1_q  <= bus.in_tag;
      sign1_q <= sign_d;
      spec1_q <= spec_d;
      sres1_q <= sres_d;
      sflg1_q <= sflg_d;
      exp1_q  <= exp_d;
      siga1_q <= {1'b1, bus.a[ManW-1:0]};
      sigb1_q <= {1'b1, bus.b[ManW-1:0]};

      tag2_q  <= tag1_q;
      sign2_q <= sign1_q;
      spec2_q <= spec1_q;
      sres2_q <= sres1_q;
      sflg2_q <= sflg1_q;
      exp2_q  <= exp1_q;
      prod2_q <= prod_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v3_q;
  assign bus.out       = out_q;
  assign bus.out_tag   = tag3_q;
  assign bus.out_flags = flags3_q;

endmodule
